// File: rtl/decode_unit_if.sv
// Instruction-in / decoded-bundle-out handshake bundle for decode_unit.
// The master side offers instructions and consumes bundles; the slave side
// is the decoder itself.
interface decode_unit_if #(
  parameter int REG_BITS = 5
) ();
  logic                in_valid;
  logic [31:0]         instruction;
  logic                in_ready;
  logic                flush;
  logic                out_ready;
  logic                out_valid;
  logic [1:0]          alu_op;
  logic [REG_BITS-1:0] reg_a;
  logic [REG_BITS-1:0] reg_b;
  logic [REG_BITS-1:0] reg_d;
  logic [31:0]         imm;
  logic                is_immediate;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                mem_byte;
  logic                branch;
  logic                jump;
  logic                illegal;

  modport master (
    output in_valid, instruction, flush, out_ready,
    input  in_ready, out_valid, alu_op, reg_a, reg_b, reg_d, imm,
           is_immediate, reg_write, mem_read, mem_write, mem_byte,
           branch, jump, illegal
  );

  modport slave (
    input  in_valid, instruction, flush, out_ready,
    output in_ready, out_valid, alu_op, reg_a, reg_b, reg_d, imm,
           is_immediate, reg_write, mem_read, mem_write, mem_byte,
           branch, jump, illegal
  );
endinterface

// File: rtl/decode_unit.sv
// Single-stage instruction decoder with a registered output bundle and a
// one-entry scoreboard that stalls consumers of an in-flight load or MUL
// result. A second load/MUL is also held off while an entry is pending.
module decode_unit #(
  parameter int REG_BITS = 5,
  parameter int LD_LAT   = 1,
  parameter int MUL_LAT  = 4
) (
  input logic         clk,
  input logic         reset,
  decode_unit_if.slave bus
);

  localparam logic [6:0] OP_ADD  = 7'h00;
  localparam logic [6:0] OP_SUB  = 7'h01;
  localparam logic [6:0] OP_MUL  = 7'h02;
  localparam logic [6:0] OP_LDB  = 7'h10;
  localparam logic [6:0] OP_LDW  = 7'h11;
  localparam logic [6:0] OP_STB  = 7'h12;
  localparam logic [6:0] OP_STW  = 7'h13;
  localparam logic [6:0] OP_MOV  = 7'h14;
  localparam logic [6:0] OP_BEQ  = 7'h30;
  localparam logic [6:0] OP_JUMP = 7'h31;

  localparam int CNT_MAX = (LD_LAT > MUL_LAT) ? LD_LAT : MUL_LAT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LD_CNT  = CNT_W'(LD_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic [1:0]          alu_op;
    logic [REG_BITS-1:0] reg_a;
    logic [REG_BITS-1:0] reg_b;
    logic [REG_BITS-1:0] reg_d;
    logic [31:0]         imm;
    logic                is_immediate;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_byte;
    logic                branch;
    logic                jump;
    logic                illegal;
  } bundle_t;

  function automatic logic [31:0] sext15(input logic [14:0] v);
    sext15 = {{17{v[14]}}, v};
  endfunction

  function automatic logic [31:0] sext20(input logic [19:0] v);
    sext20 = {{12{v[19]}}, v};
  endfunction

  function automatic logic [31:0] sext25(input logic [24:0] v);
    sext25 = {{7{v[24]}}, v};
  endfunction

  logic [6:0]          opcode_s;
  logic [REG_BITS-1:0] fld_d_s;
  logic [REG_BITS-1:0] fld_a_s;
  logic [REG_BITS-1:0] fld_b_s;
  bundle_t             dec_s;
  logic                wr_s;
  logic                rd_a_s;
  logic                rd_b_s;
  logic                is_ld_s;
  logic                is_mul_s;
  logic                src_hit_s;
  logic                hazard_s;
  logic                in_ready_s;
  logic                accept_s;
  logic                issue_s;

  bundle_t             bundle_q, bundle_d;
  logic                valid_q, valid_d;
  logic [REG_BITS-1:0] pend_reg_q, pend_reg_d;
  logic [CNT_W-1:0]    pend_cnt_q, pend_cnt_d;

  assign opcode_s = bus.instruction[31:25];
  assign fld_d_s  = REG_BITS'(bus.instruction[24:20]);
  assign fld_a_s  = REG_BITS'(bus.instruction[19:15]);
  assign fld_b_s  = REG_BITS'(bus.instruction[14:10]);

  // Decode the offered instruction word into a bundle plus its source-read set.
  always_comb begin
    dec_s    = '0;
    wr_s     = 1'b0;
    rd_a_s   = 1'b0;
    rd_b_s   = 1'b0;
    is_ld_s  = 1'b0;
    is_mul_s = 1'b0;
    case (opcode_s)
      OP_ADD, OP_SUB, OP_MUL: begin
        dec_s.reg_d  = fld_d_s;
        dec_s.reg_a  = fld_a_s;
        dec_s.reg_b  = fld_b_s;
        dec_s.alu_op = (opcode_s == OP_ADD) ? 2'b00 :
                       (opcode_s == OP_SUB) ? 2'b01 : 2'b10;
        wr_s         = 1'b1;
        rd_a_s       = 1'b1;
        rd_b_s       = 1'b1;
        is_mul_s     = (opcode_s == OP_MUL);
      end
      OP_LDB, OP_LDW: begin
        dec_s.reg_d        = fld_d_s;
        dec_s.reg_a        = fld_a_s;
        dec_s.imm          = sext15(bus.instruction[14:0]);
        dec_s.is_immediate = 1'b1;
        dec_s.mem_read     = 1'b1;
        dec_s.mem_byte     = (opcode_s == OP_LDB);
        wr_s               = 1'b1;
        rd_a_s             = 1'b1;
        is_ld_s            = 1'b1;
      end
      OP_STB, OP_STW: begin
        // Stores carry the data register in the destination field.
        dec_s.reg_a        = fld_a_s;
        dec_s.reg_b        = fld_d_s;
        dec_s.imm          = sext15(bus.instruction[14:0]);
        dec_s.is_immediate = 1'b1;
        dec_s.mem_write    = 1'b1;
        dec_s.mem_byte     = (opcode_s == OP_STB);
        rd_a_s             = 1'b1;
        rd_b_s             = 1'b1;
      end
      OP_MOV: begin
        dec_s.reg_d        = fld_d_s;
        dec_s.imm          = sext20(bus.instruction[19:0]);
        dec_s.alu_op       = 2'b11;
        dec_s.is_immediate = 1'b1;
        wr_s               = 1'b1;
      end
      OP_BEQ: begin
        dec_s.reg_a  = fld_a_s;
        dec_s.reg_b  = fld_b_s;
        dec_s.imm    = sext15({bus.instruction[24:20], bus.instruction[9:0]});
        dec_s.alu_op = 2'b01;
        dec_s.branch = 1'b1;
        rd_a_s       = 1'b1;
        rd_b_s       = 1'b1;
      end
      OP_JUMP: begin
        dec_s.imm  = sext25(bus.instruction[24:0]);
        dec_s.jump = 1'b1;
      end
      default: begin
        dec_s.illegal = 1'b1;
      end
    endcase
    // Writes to register 0 are discarded.
    dec_s.reg_write = wr_s & (dec_s.reg_d != '0);
  end

  // Stall when the offered instruction reads the pending register or would
  // need a second scoreboard entry.
  always_comb begin
    src_hit_s = (rd_a_s && (dec_s.reg_a != '0) && (dec_s.reg_a == pend_reg_q)) ||
                (rd_b_s && (dec_s.reg_b != '0) && (dec_s.reg_b == pend_reg_q));
    hazard_s  = bus.in_valid && (pend_cnt_q != '0) && (src_hit_s || is_ld_s || is_mul_s);
  end

  assign in_ready_s = (!valid_q || bus.out_ready) && !hazard_s && !bus.flush && !reset;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign issue_s    = valid_q && bus.out_ready;

  // Next-state for the output stage and scoreboard; flush wins over all else.
  always_comb begin
    bundle_d   = bundle_q;
    valid_d    = valid_q;
    pend_reg_d = pend_reg_q;
    pend_cnt_d = pend_cnt_q;
    if (bus.flush) begin
      valid_d    = 1'b0;
      pend_cnt_d = '0;
    end else begin
      if (accept_s) begin
        bundle_d = dec_s;
        valid_d  = 1'b1;
      end else if (issue_s) begin
        valid_d  = 1'b0;
      end else begin
        valid_d  = valid_q;
      end
      if (issue_s && bundle_q.reg_write && bundle_q.mem_read) begin
        pend_reg_d = bundle_q.reg_d;
        pend_cnt_d = LD_CNT;
      end else if (issue_s && bundle_q.reg_write && (bundle_q.alu_op == 2'b10)) begin
        pend_reg_d = bundle_q.reg_d;
        pend_cnt_d = MUL_CNT;
      end else if (pend_cnt_q != '0) begin
        pend_cnt_d = pend_cnt_q - CNT_ONE;
      end else begin
        pend_cnt_d = pend_cnt_q;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bundle_q   <= '0;
      valid_q    <= 1'b0;
      pend_reg_q <= '0;
      pend_cnt_q <= '0;
    end else begin
      bundle_q   <= bundle_d;
      valid_q    <= valid_d;
      pend_reg_q <= pend_reg_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = valid_q;
  assign bus.alu_op       = bundle_q.alu_op;
  assign bus.reg_a        = bundle_q.reg_a;
  assign bus.reg_b        = bundle_q.reg_b;
  assign bus.reg_d        = bundle_q.reg_d;
  assign bus.imm          = bundle_q.imm;
  assign bus.is_immediate = bundle_q.is_immediate;
  assign bus.reg_write    = bundle_q.reg_write;
  assign bus.mem_read     = bundle_q.mem_read;
  assign bus.mem_write    = bundle_q.mem_write;
  assign bus.mem_byte     = bundle_q.mem_byte;
  assign bus.branch       = bundle_q.branch;
  assign bus.jump         = bundle_q.jump;
  assign bus.illegal      = bundle_q.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: the driver pushes the hand-computed
// bundle when an instruction is accepted, a negedge monitor compares every
// presented bundle against the queue head.
module tb_decode_unit;

  typedef struct packed {
    logic [1:0]  alu;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  d;
    logic [31:0] imm;
    logic [7:0]  fl;  // {is_imm, reg_write, mem_read, mem_write, mem_byte, branch, jump, illegal}
  } bundle_t;

  localparam logic [7:0] F_IMM = 8'h80;
  localparam logic [7:0] F_RW  = 8'h40;
  localparam logic [7:0] F_MR  = 8'h20;
  localparam logic [7:0] F_MW  = 8'h10;
  localparam logic [7:0] F_MB  = 8'h08;
  localparam logic [7:0] F_BR  = 8'h04;
  localparam logic [7:0] F_JP  = 8'h02;
  localparam logic [7:0] F_IL  = 8'h01;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_unit_if #(.REG_BITS(5)) bus ();

  decode_unit #(.REG_BITS(5), .LD_LAT(1), .MUL_LAT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bundle_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bundle_t mk(input logic [1:0] alu, input logic [4:0] a,
                                 input logic [4:0] b, input logic [4:0] d,
                                 input logic [31:0] imm, input logic [7:0] fl);
    return {alu, a, b, d, imm, fl};
  endfunction

  function automatic bundle_t act();
    return {bus.alu_op, bus.reg_a, bus.reg_b, bus.reg_d, bus.imm,
            bus.is_immediate, bus.reg_write, bus.mem_read, bus.mem_write,
            bus.mem_byte, bus.branch, bus.jump, bus.illegal};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: compare every presented bundle with the scoreboard head.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_bundle: got %h, expected none", act());
      end else begin
        check("bundle", 64'(act()), 64'(exp_q[0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one instruction, count stall cycles, push expectation on accept.
  task automatic send(input string name, input logic [31:0] ins,
                      input bundle_t e, input int exp_stall);
    int stalls = 0;
    bit ok = 1'b0;
    bus.in_valid    = 1'b1;
    bus.instruction = ins;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        exp_q.push_back(e);
      end else begin
        stalls++;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no accept, expected accept within 50 cycles", name);
    end else if (exp_stall >= 0) begin
      check({name, "_stall"}, 64'(stalls), 64'(exp_stall));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.instruction = 32'h0000_0000;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b1;

    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_outputs", 64'(act()), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic R-type.
    send("add_r3", 32'h0030_8800, mk(2'b00, 5'd1, 5'd2, 5'd3, 32'h0, F_RW), 0);

    // Load-use: one stall cycle.
    send("ldw_r4", 32'h2240_FFFC, mk(2'b00, 5'd1, 5'd0, 5'd4, 32'hFFFF_FFFC, F_IMM | F_RW | F_MR), 0);
    idle(1);
    send("add_r5_dep", 32'h0052_0800, mk(2'b00, 5'd4, 5'd2, 5'd5, 32'h0, F_RW), 1);
    idle(2);

    // MUL-use: four stall cycles.
    send("mul_r6", 32'h0460_8800, mk(2'b10, 5'd1, 5'd2, 5'd6, 32'h0, F_RW), 0);
    idle(1);
    send("sub_r7_dep", 32'h0273_1800, mk(2'b01, 5'd6, 5'd6, 5'd7, 32'h0, F_RW), 4);

    // Independent instruction after a MUL is not stalled.
    send("mul_r6_b", 32'h0460_8800, mk(2'b10, 5'd1, 5'd2, 5'd6, 32'h0, F_RW), 0);
    idle(1);
    send("add_r8_indep", 32'h0080_8800, mk(2'b00, 5'd1, 5'd2, 5'd8, 32'h0, F_RW), 0);
    idle(5);

    // Backpressure: bundle held three cycles, next one accepted when ready rises.
    bus.out_ready = 1'b0;
    send("add_r9", 32'h0090_8800, mk(2'b00, 5'd1, 5'd2, 5'd9, 32'h0, F_RW), 0);
    fork
      send("sub_r10_bp", 32'h02A0_8800, mk(2'b01, 5'd1, 5'd2, 5'd10, 32'h0, F_RW), 3);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join

    // Illegal opcode and writes to r0.
    send("illegal", 32'hFE00_0000, mk(2'b00, 5'd0, 5'd0, 5'd0, 32'h0, F_IL), 0);
    send("add_r0", 32'h0000_8800, mk(2'b00, 5'd1, 5'd2, 5'd0, 32'h0, 8'h00), 0);

    // Remaining formats.
    send("stb", 32'h2421_8008, mk(2'b00, 5'd3, 5'd2, 5'd0, 32'h0000_0008, F_IMM | F_MW | F_MB), 0);
    send("mov", 32'h28BF_FFFF, mk(2'b11, 5'd0, 5'd0, 5'd11, 32'hFFFF_FFFF, F_IMM | F_RW), 0);
    send("beq", 32'h6100_8804, mk(2'b01, 5'd1, 5'd2, 5'd0, 32'hFFFF_C004, F_BR), 0);
    send("jump", 32'h63FF_FFF0, mk(2'b00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF0, F_JP), 0);
    send("ldb_r12", 32'h20C0_0005, mk(2'b00, 5'd0, 5'd0, 5'd12, 32'h0000_0005, F_IMM | F_RW | F_MR | F_MB), 0);
    idle(1);
    send("stw_data_dep", 32'h26C0_8000, mk(2'b00, 5'd1, 5'd12, 5'd0, 32'h0, F_IMM | F_MW), 1);
    idle(2);

    // Flush during a MUL stall drops the offered instruction and the pending entry.
    send("mul_r6_f", 32'h0460_8800, mk(2'b10, 5'd1, 5'd2, 5'd6, 32'h0, F_RW), 0);
    idle(1);
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h0080_8800;
    bus.flush       = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    fork
      send("sub_after_flush", 32'h0273_1800, mk(2'b01, 5'd6, 5'd6, 5'd7, 32'h0, F_RW), 0);
      begin
        @(negedge clk);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      end
    join
    idle(2);

    // Reset pulsed mid-stall clears everything.
    send("mul_r6_r", 32'h0460_8800, mk(2'b10, 5'd1, 5'd2, 5'd6, 32'h0, F_RW), 0);
    idle(1);
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h0273_1800;
    @(negedge clk);
    check("stall_before_reset", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_outputs", 64'(act()), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send("sub_after_reset", 32'h0273_1800, mk(2'b01, 5'd6, 5'd6, 5'd7, 32'h0, F_RW), 0);

    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
